// File: rtl/pte_walk_cache_module_pkg.sv
// Purpose: shared MMU definitions for the leaf-PTE walk cache (widths, privilege modes, flush FSM states).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pte_walk_cache_module_pkg;

    localparam int PTE_WIDTH = 32;

    // Privilege-mode encodings as carried on the lookup/fill mode inputs.
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Cached entry payload: {level, pte}.
    localparam int PTE_CACHE_DATA_WIDTH = 2 + PTE_WIDTH;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_SWEEP = 2'd1,
        FLUSH_DONE  = 2'd2
    } flush_state_e;

endpackage

// File: rtl/pte_walk_cache_module_plru.sv
// Purpose: tree-PLRU helper; computes the updated tree for an access and the current victim way.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   tree_i    - current tree bits (WAYS-1), heap order: node n has children 2n+1 / 2n+2
//   acc_vld_i - an access updates the tree
//   acc_way_i - accessed way
//   tree_o    - tree after the access (equals tree_i when acc_vld_i is low)
//   victim_o  - way the current tree (tree_i) points at
module plru_tree_module #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         tree_i,
    input  logic                    acc_vld_i,
    input  logic [$clog2(WAYS)-1:0] acc_way_i,
    output logic [WAYS-2:0]         tree_o,
    output logic [$clog2(WAYS)-1:0] victim_o
);

    localparam int LOGW = $clog2(WAYS);
    localparam logic [LOGW-1:0] ONE = LOGW'(1);

    // A node bit of 0 points at its left subtree, 1 at the right. An access
    // makes every node on its path point away from the accessed way.
    always_comb begin
        logic [LOGW-1:0] node;
        logic            dir;
        tree_o = tree_i;
        node   = '0;
        dir    = 1'b0;
        if (acc_vld_i) begin
            for (int l = 0; l < LOGW; l++) begin
                dir          = acc_way_i[LOGW-1-l];
                tree_o[node] = ~dir;
                // Overflow on the final step is harmless: node is not used again.
                node         = (node << 1) + ONE + (dir ? ONE : '0);
            end
        end
    end

    always_comb begin
        logic [LOGW-1:0] node;
        logic            dir;
        victim_o = '0;
        node     = '0;
        dir      = 1'b0;
        for (int l = 0; l < LOGW; l++) begin
            dir                    = tree_i[node];
            victim_o[LOGW-1-l]     = dir;
            node                   = (node << 1) + ONE + (dir ? ONE : '0);
        end
    end

endmodule

// File: rtl/pte_walk_cache_module.sv
// Purpose: set-associative cache of leaf Sv32 PTEs between the TLB miss path and the walker, with SFENCE.VMA sweep.
// Latency: lookup response 1 cycle after accept; fill visible next cycle; flush done SETS+1 (full) or 2 (single VA) cycles after accept.
// Backpressure: o_lkp_rdy/o_flush_rdy low while a flush sweeps; fills arriving outside IDLE (or with a flush accept) are dropped.
//
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   i_lkp_* / o_lkp_rdy             - lookup request {vaddr, asid, mode}
//   o_rsp_*                         - registered one-cycle response {hit, level, pte}
//   i_fill_*                        - walker fill {vaddr, asid, mode, level, pte}
//   i_flush_* / o_flush_rdy/_done   - SFENCE.VMA request and completion pulse
module pte_walk_cache_module
    import pte_walk_cache_module_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int WAYS   = 4,
    parameter int ASID_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_lkp_vld,
    input  logic [31:0]       i_lkp_vaddr,
    input  logic [ASID_W-1:0] i_lkp_asid,
    input  logic [1:0]        i_lkp_mode,
    output logic              o_lkp_rdy,
    output logic              o_rsp_vld,
    output logic              o_rsp_hit,
    output logic [1:0]        o_rsp_level,
    output logic [31:0]       o_rsp_pte,
    input  logic              i_fill_vld,
    input  logic [31:0]       i_fill_vaddr,
    input  logic [ASID_W-1:0] i_fill_asid,
    input  logic [1:0]        i_fill_mode,
    input  logic [1:0]        i_fill_level,
    input  logic [31:0]       i_fill_pte,
    input  logic              i_flush_vld,
    input  logic              i_flush_va_en,
    input  logic [31:0]       i_flush_vaddr,
    input  logic              i_flush_asid_en,
    input  logic [ASID_W-1:0] i_flush_asid,
    output logic              o_flush_rdy,
    output logic              o_flush_done
);

    localparam int IDXW = $clog2(SETS);
    localparam int LOGW = $clog2(WAYS);
    localparam int VPNW = 32 - 12 - IDXW;
    localparam logic [IDXW-1:0] LAST_SET = IDXW'(SETS - 1);

    typedef struct packed {
        logic [ASID_W-1:0] asid;
        logic [1:0]        mode;
        logic [VPNW-1:0]   vpn;
    } tag_t;

    typedef struct packed {
        logic [1:0]           level;
        logic [PTE_WIDTH-1:0] pte;
    } data_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-2:0] plru_q  [SETS];
    tag_t            tag_q   [SETS][WAYS];
    data_t           data_q  [SETS][WAYS];

    // ------------------------------------------------------------------
    // Flush FSM state
    // ------------------------------------------------------------------
    flush_state_e      state_q, state_d;
    logic [IDXW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [IDXW-1:0]   flush_last_q, flush_last_d;
    logic              flush_va_en_q, flush_va_en_d;
    logic [VPNW-1:0]   flush_vpn_q, flush_vpn_d;
    logic              flush_asid_en_q, flush_asid_en_d;
    logic [ASID_W-1:0] flush_asid_q, flush_asid_d;

    logic flush_acc;
    logic fill_acc;
    logic lkp_acc;

    assign flush_acc = i_flush_vld & (state_q == FLUSH_IDLE);
    assign fill_acc  = i_fill_vld & (state_q == FLUSH_IDLE) & ~flush_acc;
    assign lkp_acc   = i_lkp_vld & o_lkp_rdy;

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [IDXW-1:0] lkp_idx;
    tag_t            lkp_tag;
    logic [WAYS-1:0] lkp_hit_vec;
    logic            lkp_hit;
    logic [LOGW-1:0] lkp_way;
    data_t           lkp_data;
    logic [WAYS-2:0] lkp_plru_next;
    logic [LOGW-1:0] lkp_victim_unused;

    assign lkp_idx = i_lkp_vaddr[12 +: IDXW];
    assign lkp_tag = '{asid: i_lkp_asid, mode: i_lkp_mode, vpn: i_lkp_vaddr[31 -: VPNW]};

    // At most one way matches, so an OR-mux of the matching ways is exact.
    always_comb begin
        lkp_hit_vec = '0;
        lkp_way     = '0;
        lkp_data    = '0;
        for (int w = 0; w < WAYS; w++) begin
            lkp_hit_vec[w] = valid_q[lkp_idx][w] && (tag_q[lkp_idx][w] == lkp_tag);
            if (lkp_hit_vec[w]) begin
                lkp_way  = lkp_way | LOGW'(w);
                lkp_data = lkp_data | data_q[lkp_idx][w];
            end
        end
        lkp_hit = |lkp_hit_vec;
    end

    plru_tree_module #(.WAYS(WAYS)) u_plru_lkp (
        .tree_i    (plru_q[lkp_idx]),
        .acc_vld_i (lkp_acc & lkp_hit),
        .acc_way_i (lkp_way),
        .tree_o    (lkp_plru_next),
        .victim_o  (lkp_victim_unused)
    );

    // ------------------------------------------------------------------
    // Fill: overwrite an existing tag, else lowest invalid way, else PLRU victim
    // ------------------------------------------------------------------
    logic [IDXW-1:0] fill_idx;
    tag_t            fill_tag;
    data_t           fill_data;
    logic            fill_match;
    logic [LOGW-1:0] fill_match_way;
    logic            fill_has_inv;
    logic [LOGW-1:0] fill_inv_way;
    logic [LOGW-1:0] fill_victim;
    logic [LOGW-1:0] fill_way;
    logic [WAYS-2:0] fill_plru_next;

    assign fill_idx  = i_fill_vaddr[12 +: IDXW];
    assign fill_tag  = '{asid: i_fill_asid, mode: i_fill_mode, vpn: i_fill_vaddr[31 -: VPNW]};
    assign fill_data = '{level: i_fill_level, pte: i_fill_pte};

    always_comb begin
        fill_match     = 1'b0;
        fill_match_way = '0;
        fill_has_inv   = 1'b0;
        fill_inv_way   = '0;
        // Descending scan so the lowest-numbered invalid way is the one kept.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[fill_idx][w] && (tag_q[fill_idx][w] == fill_tag)) begin
                fill_match     = 1'b1;
                fill_match_way = LOGW'(w);
            end
            if (!valid_q[fill_idx][w]) begin
                fill_has_inv = 1'b1;
                fill_inv_way = LOGW'(w);
            end
        end
        if (fill_match) begin
            fill_way = fill_match_way;
        end else if (fill_has_inv) begin
            fill_way = fill_inv_way;
        end else begin
            fill_way = fill_victim;
        end
    end

    plru_tree_module #(.WAYS(WAYS)) u_plru_fill (
        .tree_i    (plru_q[fill_idx]),
        .acc_vld_i (fill_acc),
        .acc_way_i (fill_way),
        .tree_o    (fill_plru_next),
        .victim_o  (fill_victim)
    );

    // ------------------------------------------------------------------
    // Flush FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        flush_last_d    = flush_last_q;
        flush_va_en_d   = flush_va_en_q;
        flush_vpn_d     = flush_vpn_q;
        flush_asid_en_d = flush_asid_en_q;
        flush_asid_d    = flush_asid_q;
        o_flush_done    = 1'b0;
        o_flush_rdy     = (state_q == FLUSH_IDLE);
        o_lkp_rdy       = (state_q == FLUSH_IDLE);
        case (state_q)
            FLUSH_IDLE: begin
                if (i_flush_vld) begin
                    state_d         = FLUSH_SWEEP;
                    flush_va_en_d   = i_flush_va_en;
                    flush_vpn_d     = i_flush_vaddr[31 -: VPNW];
                    flush_asid_en_d = i_flush_asid_en;
                    flush_asid_d    = i_flush_asid;
                    // A single-address flush can only touch the set that address indexes.
                    flush_cnt_d     = i_flush_va_en ? i_flush_vaddr[12 +: IDXW] : '0;
                    flush_last_d    = i_flush_va_en ? i_flush_vaddr[12 +: IDXW] : LAST_SET;
                end
            end
            FLUSH_SWEEP: begin
                if (flush_cnt_q == flush_last_q) begin
                    state_d = FLUSH_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + IDXW'(1);
                end
            end
            FLUSH_DONE: begin
                o_flush_done = 1'b1;
                state_d      = FLUSH_IDLE;
            end
            default: begin
                state_d = FLUSH_IDLE;
            end
        endcase
    end

    // Ways of the swept set to invalidate this cycle; mode is deliberately ignored.
    logic [WAYS-1:0] sweep_clr;
    always_comb begin
        sweep_clr = '0;
        for (int w = 0; w < WAYS; w++) begin
            sweep_clr[w] = (state_q == FLUSH_SWEEP) && valid_q[flush_cnt_q][w]
                         && (!flush_va_en_q   || (tag_q[flush_cnt_q][w].vpn  == flush_vpn_q))
                         && (!flush_asid_en_q || (tag_q[flush_cnt_q][w].asid == flush_asid_q));
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    logic  rsp_vld_q;
    logic  rsp_hit_q;
    data_t rsp_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= FLUSH_IDLE;
            flush_cnt_q     <= '0;
            flush_last_q    <= '0;
            flush_va_en_q   <= 1'b0;
            flush_vpn_q     <= '0;
            flush_asid_en_q <= 1'b0;
            flush_asid_q    <= '0;
            rsp_vld_q       <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_data_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            flush_last_q    <= flush_last_d;
            flush_va_en_q   <= flush_va_en_d;
            flush_vpn_q     <= flush_vpn_d;
            flush_asid_en_q <= flush_asid_en_d;
            flush_asid_q    <= flush_asid_d;

            rsp_vld_q  <= lkp_acc;
            rsp_hit_q  <= lkp_acc & lkp_hit;
            rsp_data_q <= (lkp_acc & lkp_hit) ? lkp_data : '0;

            // Sweep and fill never coincide: fills are only taken in IDLE.
            if (state_q == FLUSH_SWEEP) begin
                valid_q[flush_cnt_q] <= valid_q[flush_cnt_q] & ~sweep_clr;
            end
            if (fill_acc) begin
                valid_q[fill_idx][fill_way] <= 1'b1;
            end

            // Fill update is written last so it wins over a same-set hit update.
            if (lkp_acc & lkp_hit) begin
                plru_q[lkp_idx] <= lkp_plru_next;
            end
            if (fill_acc) begin
                plru_q[fill_idx] <= fill_plru_next;
            end
        end
    end

    // Tag and data are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_acc) begin
            tag_q[fill_idx][fill_way]  <= fill_tag;
            data_q[fill_idx][fill_way] <= fill_data;
        end
    end

    assign o_rsp_vld   = rsp_vld_q;
    assign o_rsp_hit   = rsp_hit_q;
    assign o_rsp_level = rsp_data_q.level;
    assign o_rsp_pte   = rsp_data_q.pte;

    // Page-offset bits take no part in indexing or tagging.
    logic unused_bits;
    assign unused_bits = ^{i_lkp_vaddr[11:0], i_fill_vaddr[11:0], i_flush_vaddr[11:0], lkp_victim_unused};

endmodule

// File: tb/tb_pte_walk_cache_module.sv
module tb_pte_walk_cache_module;

    localparam int SETS   = 64;
    localparam int WAYS   = 4;
    localparam int ASID_W = 9;
    localparam logic [1:0] MODE_S = 2'b01;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_lkp_vld;
    logic [31:0]       i_lkp_vaddr;
    logic [ASID_W-1:0] i_lkp_asid;
    logic [1:0]        i_lkp_mode;
    logic              o_lkp_rdy;
    logic              o_rsp_vld;
    logic              o_rsp_hit;
    logic [1:0]        o_rsp_level;
    logic [31:0]       o_rsp_pte;
    logic              i_fill_vld;
    logic [31:0]       i_fill_vaddr;
    logic [ASID_W-1:0] i_fill_asid;
    logic [1:0]        i_fill_mode;
    logic [1:0]        i_fill_level;
    logic [31:0]       i_fill_pte;
    logic              i_flush_vld;
    logic              i_flush_va_en;
    logic [31:0]       i_flush_vaddr;
    logic              i_flush_asid_en;
    logic [ASID_W-1:0] i_flush_asid;
    logic              o_flush_rdy;
    logic              o_flush_done;

    int checks = 0;
    int errors = 0;

    // Response seen right after the flush-accept edge (for same-cycle lookups).
    logic        acc_rsp_vld;
    logic        acc_rsp_hit;
    logic [31:0] acc_rsp_pte;

    always #5 clk = ~clk;

    pte_walk_cache_module #(.SETS(SETS), .WAYS(WAYS), .ASID_W(ASID_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_lkp_vld       (i_lkp_vld),
        .i_lkp_vaddr     (i_lkp_vaddr),
        .i_lkp_asid      (i_lkp_asid),
        .i_lkp_mode      (i_lkp_mode),
        .o_lkp_rdy       (o_lkp_rdy),
        .o_rsp_vld       (o_rsp_vld),
        .o_rsp_hit       (o_rsp_hit),
        .o_rsp_level     (o_rsp_level),
        .o_rsp_pte       (o_rsp_pte),
        .i_fill_vld      (i_fill_vld),
        .i_fill_vaddr    (i_fill_vaddr),
        .i_fill_asid     (i_fill_asid),
        .i_fill_mode     (i_fill_mode),
        .i_fill_level    (i_fill_level),
        .i_fill_pte      (i_fill_pte),
        .i_flush_vld     (i_flush_vld),
        .i_flush_va_en   (i_flush_va_en),
        .i_flush_vaddr   (i_flush_vaddr),
        .i_flush_asid_en (i_flush_asid_en),
        .i_flush_asid    (i_flush_asid),
        .o_flush_rdy     (o_flush_rdy),
        .o_flush_done    (o_flush_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill(input logic [31:0] va, input logic [ASID_W-1:0] asid,
                        input logic [1:0] lvl, input logic [31:0] pte);
        i_fill_vld   = 1'b1;
        i_fill_vaddr = va;
        i_fill_asid  = asid;
        i_fill_mode  = MODE_S;
        i_fill_level = lvl;
        i_fill_pte   = pte;
        @(posedge clk);
        #1;
        i_fill_vld = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] va, input logic [ASID_W-1:0] asid,
                          input logic exp_hit, input logic [1:0] exp_lvl, input logic [31:0] exp_pte);
        i_lkp_vld   = 1'b1;
        i_lkp_vaddr = va;
        i_lkp_asid  = asid;
        i_lkp_mode  = MODE_S;
        @(posedge clk);
        #1;
        i_lkp_vld = 1'b0;
        chk({tag, ".vld"}, o_rsp_vld, 1);
        chk({tag, ".hit"}, o_rsp_hit, exp_hit);
        chk({tag, ".lvl"}, o_rsp_level, exp_hit ? exp_lvl : 2'd0);
        chk({tag, ".pte"}, o_rsp_pte, exp_hit ? exp_pte : 32'd0);
    endtask

    // Issues a flush (together with whatever lookup/fill is already driven), then
    // checks done timing relative to the accept edge and the ready outputs.
    task automatic do_flush(input string tag, input logic va_en, input logic [31:0] va,
                            input logic asid_en, input logic [ASID_W-1:0] asid, input int exp_cyc);
        int   cyc;
        logic rdy_low;
        i_flush_vld     = 1'b1;
        i_flush_va_en   = va_en;
        i_flush_vaddr   = va;
        i_flush_asid_en = asid_en;
        i_flush_asid    = asid;
        @(posedge clk);
        #1;
        i_flush_vld = 1'b0;
        i_fill_vld  = 1'b0;
        i_lkp_vld   = 1'b0;
        acc_rsp_vld = o_rsp_vld;
        acc_rsp_hit = o_rsp_hit;
        acc_rsp_pte = o_rsp_pte;
        cyc     = 1;
        rdy_low = 1'b1;
        while (o_flush_done !== 1'b1 && cyc < exp_cyc + 20) begin
            if (o_lkp_rdy !== 1'b0 || o_flush_rdy !== 1'b0) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (o_lkp_rdy !== 1'b0) rdy_low = 1'b0;
        chk({tag, ".done"}, o_flush_done, 1);
        chk({tag, ".done_cycle"}, cyc, exp_cyc);
        chk({tag, ".rdy_low_in_sweep"}, rdy_low, 1);
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, o_flush_done, 0);
        chk({tag, ".lkp_rdy_back"}, o_lkp_rdy, 1);
        chk({tag, ".flush_rdy_back"}, o_flush_rdy, 1);
    endtask

    initial begin
        logic done_seen;
        rst_n           = 1'b0;
        i_lkp_vld       = 1'b0;
        i_lkp_vaddr     = '0;
        i_lkp_asid      = '0;
        i_lkp_mode      = '0;
        i_fill_vld      = 1'b0;
        i_fill_vaddr    = '0;
        i_fill_asid     = '0;
        i_fill_mode     = '0;
        i_fill_level    = '0;
        i_fill_pte      = '0;
        i_flush_vld     = 1'b0;
        i_flush_va_en   = 1'b0;
        i_flush_vaddr   = '0;
        i_flush_asid_en = 1'b0;
        i_flush_asid    = '0;

        // Reset values
        do_reset();
        chk("rst.rsp_vld", o_rsp_vld, 0);
        chk("rst.rsp_hit", o_rsp_hit, 0);
        chk("rst.rsp_level", o_rsp_level, 0);
        chk("rst.rsp_pte", o_rsp_pte, 0);
        chk("rst.flush_done", o_flush_done, 0);
        chk("rst.lkp_rdy", o_lkp_rdy, 1);
        chk("rst.flush_rdy", o_flush_rdy, 1);

        // Miss, fill, hit
        lookup("t1.miss", 32'h0040_3000, 9'd5, 1'b0, 2'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("t1.rsp_pulse", o_rsp_vld, 0);
        fill(32'h0040_3000, 9'd5, 2'd0, 32'h0123_45CF);
        lookup("t1.hit", 32'h0040_3000, 9'd5, 1'b1, 2'd0, 32'h0123_45CF);

        // Replacement in set 3: A..D fill ways 0..3; hits on way 0 then 2 leave PLRU at way 1
        do_reset();
        fill(32'h0000_3000, 9'd7, 2'd1, 32'h0000_A0A0);
        fill(32'h0004_3000, 9'd7, 2'd1, 32'h0000_B0B0);
        fill(32'h0008_3000, 9'd7, 2'd1, 32'h0000_C0C0);
        fill(32'h000C_3000, 9'd7, 2'd1, 32'h0000_D0D0);
        lookup("rep.hitA", 32'h0000_3000, 9'd7, 1'b1, 2'd1, 32'h0000_A0A0);
        lookup("rep.hitC", 32'h0008_3000, 9'd7, 1'b1, 2'd1, 32'h0000_C0C0);
        fill(32'h0010_3000, 9'd7, 2'd0, 32'h0000_E0E0);
        lookup("rep.evictB", 32'h0004_3000, 9'd7, 1'b0, 2'd0, 32'h0);
        lookup("rep.A", 32'h0000_3000, 9'd7, 1'b1, 2'd1, 32'h0000_A0A0);
        lookup("rep.C", 32'h0008_3000, 9'd7, 1'b1, 2'd1, 32'h0000_C0C0);
        lookup("rep.D", 32'h000C_3000, 9'd7, 1'b1, 2'd1, 32'h0000_D0D0);
        lookup("rep.E", 32'h0010_3000, 9'd7, 1'b1, 2'd0, 32'h0000_E0E0);

        // Full flush of ASID 1: done exactly SETS+1 cycles after accept
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fill(32'h0100_0000 + (k << 12), 9'd1, 2'd1, 32'h0000_0A00 + k);
            fill(32'h0100_0000 + (k << 12), 9'd2, 2'd1, 32'h0000_0B00 + k);
        end
        do_flush("ff", 1'b0, 32'h0, 1'b1, 9'd1, SETS + 1);
        for (int k = 0; k < 5; k++) begin
            lookup($sformatf("ff.asid1_%0d", k), 32'h0100_0000 + (k << 12), 9'd1, 1'b0, 2'd0, 32'h0);
            lookup($sformatf("ff.asid2_%0d", k), 32'h0100_0000 + (k << 12), 9'd2, 1'b1, 2'd1, 32'h0000_0B00 + k);
        end

        // Single-address flush, with a lookup accepted in the same cycle as the flush
        do_reset();
        fill(32'h0040_3000, 9'd5, 2'd0, 32'h0000_0111);
        fill(32'h0040_3000, 9'd6, 2'd0, 32'h0000_0222);
        fill(32'h0044_3000, 9'd5, 2'd0, 32'h0000_0333);
        i_lkp_vld   = 1'b1;
        i_lkp_vaddr = 32'h0044_3000;
        i_lkp_asid  = 9'd5;
        i_lkp_mode  = MODE_S;
        do_flush("sf", 1'b1, 32'h0040_3000, 1'b0, 9'd0, 2);
        chk("sf.same_cycle_lkp_vld", acc_rsp_vld, 1);
        chk("sf.same_cycle_lkp_hit", acc_rsp_hit, 1);
        chk("sf.same_cycle_lkp_pte", acc_rsp_pte, 32'h0000_0333);
        lookup("sf.asid5", 32'h0040_3000, 9'd5, 1'b0, 2'd0, 32'h0);
        lookup("sf.asid6", 32'h0040_3000, 9'd6, 1'b0, 2'd0, 32'h0);
        lookup("sf.other", 32'h0044_3000, 9'd5, 1'b1, 2'd0, 32'h0000_0333);

        // Fill in the flush-accept cycle is dropped
        do_reset();
        i_fill_vld   = 1'b1;
        i_fill_vaddr = 32'h0080_5000;
        i_fill_asid  = 9'd3;
        i_fill_mode  = MODE_S;
        i_fill_level = 2'd0;
        i_fill_pte   = 32'h0000_0555;
        do_flush("col", 1'b1, 32'h0000_0000, 1'b0, 9'd0, 2);
        lookup("col.dropped", 32'h0080_5000, 9'd3, 1'b0, 2'd0, 32'h0);

        // Refill of an existing tag replaces it in place (disjoint PTE bits expose a duplicate)
        fill(32'h0080_6000, 9'd3, 2'd0, 32'h0000_00F0);
        fill(32'h0080_6000, 9'd3, 2'd1, 32'h0000_030F);
        lookup("dup.X", 32'h0080_6000, 9'd3, 1'b1, 2'd1, 32'h0000_030F);
        fill(32'h0084_6000, 9'd3, 2'd0, 32'h0000_0661);
        fill(32'h0088_6000, 9'd3, 2'd0, 32'h0000_0662);
        fill(32'h008C_6000, 9'd3, 2'd0, 32'h0000_0663);
        lookup("dup.X2", 32'h0080_6000, 9'd3, 1'b1, 2'd1, 32'h0000_030F);
        lookup("dup.Y", 32'h0084_6000, 9'd3, 1'b1, 2'd0, 32'h0000_0661);
        lookup("dup.Z", 32'h0088_6000, 9'd3, 1'b1, 2'd0, 32'h0000_0662);
        lookup("dup.W", 32'h008C_6000, 9'd3, 1'b1, 2'd0, 32'h0000_0663);

        // Reset in the middle of a full sweep
        do_reset();
        fill(32'h0000_7000, 9'd4, 2'd0, 32'h0000_0777);
        i_flush_vld     = 1'b1;
        i_flush_va_en   = 1'b0;
        i_flush_vaddr   = 32'h0;
        i_flush_asid_en = 1'b0;
        i_flush_asid    = 9'd0;
        @(posedge clk);
        #1;
        i_flush_vld = 1'b0;
        done_seen   = 1'b0;
        repeat (4) begin
            if (o_flush_done === 1'b1) done_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid.lkp_rdy", o_lkp_rdy, 1);
        chk("rstmid.flush_rdy", o_flush_rdy, 1);
        repeat (80) begin
            if (o_flush_done === 1'b1) done_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("rstmid.no_done", done_seen, 0);
        lookup("rstmid.unswept", 32'h0000_7000, 9'd4, 1'b0, 2'd0, 32'h0);
        lookup("rstmid.other", 32'h0040_3000, 9'd5, 1'b0, 2'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pte_walk_cache_module.md
# pte_walk_cache_module

Parametrised set-associative cache of leaf Sv32 page-table entries, in the MMU between the TLB miss path and the page-table walker. Lookups return a registered hit/PTE one cycle after request. Fills come from the walker on walk completion. SFENCE.VMA invalidations run as a sequential sweep with a ready/done handshake. Replacement uses per-set tree-PLRU.

## Interface
- `SETS`, 64: number of sets; power of 2, 2..512.
- `WAYS`, 4: associativity; power of 2, 2..8.
- `ASID_W`, 9: ASID width, taken from satp.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Synchronous active-low, one clock; polarity and synchronicity are fixed.
- `i_lkp_vld`  in  1  lookup request.
- `i_lkp_vaddr`  in  32  lookup virtual address.
- `i_lkp_asid`  in  ASID_W  lookup ASID.
- `i_lkp_mode`  in  2  current privilege mode.
- `o_lkp_rdy`  out  1  lookup can be accepted. 0 while a flush is in progress.
- `o_rsp_vld`  out  1  lookup response valid.
- `o_rsp_hit`  out  1  lookup hit.
- `o_rsp_level`  out  2  level of the hit PTE.
- `o_rsp_pte`  out  32  hit PTE; 0 on miss.
- `i_fill_vld`  in  1  walker fill request.
- `i_fill_vaddr`  in  32  fill virtual address.
- `i_fill_asid`  in  ASID_W  fill ASID.
- `i_fill_mode`  in  2  fill mode.
- `i_fill_level`  in  2  fill level.
- `i_fill_pte`  in  32  fill PTE.
- `i_flush_vld`  in  1  flush request.
- `i_flush_va_en`  in  1  rs1 != x0: flush a single address.
- `i_flush_vaddr`  in  32  flush address.
- `i_flush_asid_en`  in  1  rs2 != x0: flush a single ASID.
- `i_flush_asid`  in  ASID_W  flush ASID.
- `o_flush_rdy`  out  1  flush request can be accepted.
- `o_flush_done`  out  1  one-cycle pulse when the flush is complete.

## Operation
- Index and tag:
  - IDXW = log2(SETS). Index = vaddr[12+IDXW-1:12].
  - Tag = {asid, mode, vaddr[31:12+IDXW]}.
  - Entry data = {level, pte}.
- Lookup:
  - Accepted when `i_lkp_vld & o_lkp_rdy`.
  - Hit = a valid way whose tag equals the request tag. A tag is never present twice in a set.
  - On hit, the set's PLRU is updated toward the hit way.
- Fill:
  - Accepted when `i_fill_vld` and the FSM is in IDLE with no flush accepted that cycle. Otherwise the fill is silently dropped.
  - If the tag is already present, that way is overwritten.
  - Otherwise the victim is the lowest-numbered invalid way; if the set is full, the victim is the PLRU way.
  - Sets valid, writes tag and data, and updates PLRU toward the written way.
- PLRU: per-set tree of WAYS-1 bits. Reset value 0, which points at way 0.
- Flush FSM:
  - States are IDLE, SWEEP and DONE. `o_flush_rdy` = (state == IDLE).
  - IDLE -> SWEEP on an accepted flush. The FSM latches va_en, vaddr, asid_en and asid.
  - If va_en = 1: the sweep counter is loaded with the vaddr index and the last-set is that same index (a single set).
  - If va_en = 0: the counter is loaded with 0 and the last-set is SETS-1.
  - In SWEEP, each cycle, the FSM clears valid in every way of set[counter] that matches:
    - VPN match (the tag VPN bits equal those of the flush vaddr) if va_en;
    - AND ASID match if asid_en;
    - mode is not compared.
  - SWEEP -> DONE when counter == last-set. Otherwise the counter increments.
  - DONE: `o_flush_done` = 1 for one cycle, then the FSM returns to IDLE.
- Simultaneous events:
  - A flush accepted in the same cycle as a fill wins; the fill is dropped.
  - A lookup and a fill to the same set in the same cycle: the lookup sees the pre-fill contents.
  - A hit-PLRU update and a fill PLRU update in the same set in the same cycle: the fill update wins.
- Reset, including mid-sweep:
  - All valid bits, PLRU bits and the FSM are cleared, and the FSM returns to IDLE.
  - No `o_flush_done` is issued for an aborted flush.
  - Tag and data arrays are not reset.

## Timing
- Lookup latency is 1: accepted at cycle N, response at N+1. The response is a one-cycle pulse.
- Full pipelining: one lookup per cycle in IDLE.
- A fill accepted at N is visible to a lookup accepted at N+1.
- Full flush accepted at N:
  - sets are swept in cycles N+1..N+SETS;
  - `o_flush_done` is asserted at N+SETS+1;
  - `o_flush_rdy` and `o_lkp_rdy` return to 1 at N+SETS+2.
- Single-address flush accepted at N: done at N+2, ready at N+3.
- `o_lkp_rdy` is 0 from N+1 until the FSM is back in IDLE.
- A lookup accepted at N, the same cycle a flush is accepted, completes normally at N+1.
- Reset values of all outputs:
  - `o_rsp_vld`, `o_rsp_hit`, `o_rsp_level`, `o_rsp_pte` and `o_flush_done` are 0;
  - `o_lkp_rdy` and `o_flush_rdy` are 1.

## Structure
- The shared MMU package holds:
  - `PTE_WIDTH` (32);
  - the privilege-mode encodings;
  - `PTE_CACHE_DATA_WIDTH` (2+PTE_WIDTH);
  - the flush FSM state encodings.
- One sub-module, `plru_tree_module` (parameter WAYS), combinational:
  - inputs: current tree bits, access valid, access way;
  - outputs: next tree bits and victim way.
  - It is instantiated once for the lookup set and once for the fill set.
- Valid, tag and data are stored in flop arrays of SETS×WAYS entries.

## Test plan
- Miss then fill:
  - lookup VA 0x0040_3000, ASID 5 -> `o_rsp_hit` = 0 at N+1;
  - fill {level 0, PTE 0x1234_5CF};
  - re-lookup -> hit with pte 0x1234_5CF, level 0.
- Replacement (SETS=64, WAYS=4):
  - fill 4 VAs that share index 3;
  - hit way 0, then way 2;
  - a fifth fill evicts way 1;
  - lookup of the original way-1 VA misses, and the other three hit.
- Full flush:
  - fill 10 entries across ASIDs 1 and 2;
  - flush with va_en=0, asid_en=1, ASID=1;
  - `o_flush_done` exactly SETS+1 cycles after accept;
  - ASID-1 entries miss and ASID-2 entries hit;
  - `o_lkp_rdy` is low throughout the sweep.
- Single-address flush:
  - flush va_en=1, VA 0x0040_3000, asid_en=0;
  - done at N+2;
  - every ASID at that VA misses, and other VAs in the same set hit.
- Collisions:
  - fill asserted in the same cycle as a flush accept -> the fill is dropped and a later lookup misses;
  - a fill to an existing tag -> the data is replaced with no duplicate, and a single way hits.
- Reset mid-sweep:
  - assert `rst_n`=0 at N+5 of a full flush;
  - no `o_flush_done`;
  - all lookups miss;
  - both ready outputs are 1 the cycle after reset is released.
